// File: rtl/binary_arith_pkg.sv
// Shared types and width helpers for the binary dot-product accumulation path.
package binary_arith_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Accumulated width that cannot overflow for nb signed in_w-bit partials.
    function automatic int unsigned out_width(input int unsigned in_w, input int unsigned nb);
        return in_w + int'($clog2(nb)) + 1;
    endfunction

    // Counter width that still holds 0 when only one block exists.
    function automatic int unsigned cnt_width(input int unsigned nb);
        return (nb > 1) ? int'($clog2(nb)) : 1;
    endfunction

endpackage

// File: rtl/binary_block_counter.sv
// Wrap counter 0..NUM_BLOCKS-1, advancing on inc and flagging the final block.
module binary_block_counter
    import binary_arith_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic is_last
);

    localparam int unsigned CNT_W = cnt_width(NUM_BLOCKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BLOCKS - 1);

    logic [CNT_W-1:0] cnt_q;

    assign is_last = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= is_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/binary_dot_product_block_accumulator.sv
// Sums NUM_BLOCKS signed partials per result behind a registered valid/ready output.
// Define BINARY_ACC_THRESHOLD_EN to add the binarized output data_out_bin.
module binary_dot_product_block_accumulator
    import binary_arith_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 4,
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned OUT_WIDTH  = out_width(IN_WIDTH, NUM_BLOCKS)
`ifdef BINARY_ACC_THRESHOLD_EN
    ,
    parameter int          THRESHOLD  = 0
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [IN_WIDTH-1:0]  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        data_out_valid,
    input  logic                        data_out_ready
`ifdef BINARY_ACC_THRESHOLD_EN
    ,
    output logic                        data_out_bin
`endif
);

    acc_state_t                  state_q, state_d;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] out_d;
    logic signed [OUT_WIDTH-1:0] din_ext;
    logic signed [OUT_WIDTH-1:0] sum;
    logic                        valid_d;
    logic                        accept;
    logic                        is_last;
    logic                        load_out;

    binary_block_counter #(
        .NUM_BLOCKS (NUM_BLOCKS)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .inc     (accept),
        .is_last (is_last)
    );

    assign din_ext = OUT_WIDTH'(data_in);
    assign sum     = acc_q + din_ext;
    assign accept  = data_in_valid && data_in_ready;

    // A last beat may only enter HOLD when the held result drains this cycle.
    always_comb begin
        data_in_ready = 1'b1;
        if (state_q == HOLD) begin
            data_in_ready = !is_last || data_out_ready;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        out_d    = data_out;
        valid_d  = data_out_valid;
        load_out = 1'b0;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (is_last) begin
                        load_out = 1'b1;
                        out_d    = sum;
                        valid_d  = 1'b1;
                        acc_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        acc_d = sum;
                    end
                end
            end
            HOLD: begin
                if (accept && !is_last) begin
                    acc_d = sum;
                end
                if (data_out_ready) begin
                    if (accept && is_last) begin
                        load_out = 1'b1;
                        out_d    = sum;
                        acc_d    = '0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ACCUM;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ACCUM;
            acc_q          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            data_out       <= out_d;
            data_out_valid <= valid_d;
        end
    end

`ifdef BINARY_ACC_THRESHOLD_EN
    localparam logic signed [OUT_WIDTH-1:0] THRESH = OUT_WIDTH'(THRESHOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_bin <= 1'b0;
        end else if (load_out) begin
            data_out_bin <= (sum >= THRESH);
        end
    end
`else
    logic unused_load_out;
    assign unused_load_out = load_out;
`endif

endmodule

// File: tb/tb_binary_dot_product_block_accumulator.sv
// Directed self-checking bench for binary_dot_product_block_accumulator (NUM_BLOCKS=4 and 1).
module tb_binary_dot_product_block_accumulator;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [3:0] data_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic signed [6:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready;

    logic signed [3:0] d1_in;
    logic              d1_in_valid;
    logic              d1_in_ready;
    logic signed [4:0] d1_out;
    logic              d1_out_valid;

    int checks   = 0;
    int failures = 0;

`ifdef BINARY_ACC_THRESHOLD_EN
    logic data_out_bin;
    logic d1_out_bin;
`endif

    always #5 clk = ~clk;

    binary_dot_product_block_accumulator #(
        .IN_WIDTH   (4),
        .NUM_BLOCKS (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
`ifdef BINARY_ACC_THRESHOLD_EN
        ,
        .data_out_bin   (data_out_bin)
`endif
    );

    binary_dot_product_block_accumulator #(
        .IN_WIDTH   (4),
        .NUM_BLOCKS (1)
    ) dut1 (
        .clk            (clk),
        .rst            (rst),
        .data_in        (d1_in),
        .data_in_valid  (d1_in_valid),
        .data_in_ready  (d1_in_ready),
        .data_out       (d1_out),
        .data_out_valid (d1_out_valid),
        .data_out_ready (1'b1)
`ifdef BINARY_ACC_THRESHOLD_EN
        ,
        .data_out_bin   (d1_out_bin)
`endif
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat at the falling edge and let the next rising edge take it.
    task automatic beat(input logic signed [3:0] v, input logic vld);
        @(negedge clk);
        data_in       = v;
        data_in_valid = vld;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        data_in_valid = 1'b0;
        data_in       = 4'sd0;
    endtask

    initial begin
        rst            = 1'b0;
        data_in        = 4'sd0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        d1_in          = 4'sd0;
        d1_in_valid    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", data_out, 0);
        check("reset_valid", {31'd0, data_out_valid}, 0);
        check("reset_in_ready", {31'd0, data_in_ready}, 1);
        rst = 1'b1;

        // Basic sum 3,-2,5,1 with an always-ready sink.
        beat(4'sd3, 1'b1);
        beat(-4'sd2, 1'b1);
        beat(4'sd5, 1'b1);
        check("basic_not_yet_valid", {31'd0, data_out_valid}, 0);
        beat(4'sd1, 1'b1);
        idle();
        check("basic_sum", data_out, 7);
        check("basic_valid", {31'd0, data_out_valid}, 1);
        @(negedge clk);
        check("basic_valid_one_cycle", {31'd0, data_out_valid}, 0);

        // Extremes at the edges of the signed input range.
        for (int i = 0; i < 4; i++) beat(-4'sd8, 1'b1);
        idle();
        check("min_sum", data_out, -32);
        for (int i = 0; i < 4; i++) beat(4'sd7, 1'b1);
        idle();
        check("max_sum", data_out, 28);

        // Backpressure: hold a result of 10 while the next group arrives.
        @(negedge clk);
        data_out_ready = 1'b0;
        beat(4'sd4, 1'b1);
        beat(4'sd3, 1'b1);
        beat(4'sd2, 1'b1);
        beat(4'sd1, 1'b1);
        idle();
        check("bp_first_sum", data_out, 10);
        check("bp_first_valid", {31'd0, data_out_valid}, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_in       = 4'sd1;
            data_in_valid = 1'b1;
            check("bp_nonlast_ready", {31'd0, data_in_ready}, 1);
            @(posedge clk);
        end
        @(negedge clk);
        data_in       = 4'sd1;
        data_in_valid = 1'b1;
        check("bp_last_stalled", {31'd0, data_in_ready}, 0);
        check("bp_out_stable", data_out, 10);
        @(posedge clk);
        @(negedge clk);
        check("bp_out_still_stable", data_out, 10);
        check("bp_still_stalled", {31'd0, data_in_ready}, 0);
        data_out_ready = 1'b1;
        #1;
        check("bp_ready_releases", {31'd0, data_in_ready}, 1);
        @(posedge clk);
        idle();
        check("bp_second_sum", data_out, 4);
        check("bp_valid_continuous", {31'd0, data_out_valid}, 1);
        @(negedge clk);
        check("bp_drained", {31'd0, data_out_valid}, 0);

        // Bubbles with garbage on invalid cycles.
        beat(4'sd2, 1'b1);
        beat(4'sd7, 1'b0);
        beat(-4'sd8, 1'b0);
        beat(4'sd2, 1'b1);
        beat(4'sd5, 1'b0);
        beat(4'sd2, 1'b1);
        check("bubble_not_early", {31'd0, data_out_valid}, 0);
        beat(4'sd2, 1'b1);
        idle();
        check("bubble_sum", data_out, 8);

        // Reset while a result is held and a new group is half accumulated.
        data_out_ready = 1'b0;
        beat(4'sd5, 1'b1);
        beat(4'sd5, 1'b1);
        #2;
        data_in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("async_rst_out", data_out, 0);
        check("async_rst_valid", {31'd0, data_out_valid}, 0);
        @(negedge clk);
        rst = 1'b1;
        data_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(4'sd1, 1'b1);
        idle();
        check("post_rst_sum", data_out, 4);

        // Sums near the binarization threshold.
        beat(-4'sd1, 1'b1);
        for (int i = 0; i < 3; i++) beat(4'sd0, 1'b1);
        idle();
        check("sum_minus_one", data_out, -1);
`ifdef BINARY_ACC_THRESHOLD_EN
        check("bin_minus_one", {31'd0, data_out_bin}, 0);
`endif
        for (int i = 0; i < 4; i++) beat(4'sd0, 1'b1);
        idle();
        check("sum_zero", data_out, 0);
        check("sum_zero_valid", {31'd0, data_out_valid}, 1);
`ifdef BINARY_ACC_THRESHOLD_EN
        check("bin_zero", {31'd0, data_out_bin}, 1);
`endif

        // Single-block instance: every beat is a last beat.
        @(negedge clk);
        d1_in       = -4'sd3;
        d1_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d1_in_valid = 1'b0;
        check("nb1_out", d1_out, -3);
        check("nb1_valid", {31'd0, d1_out_valid}, 1);
`ifdef BINARY_ACC_THRESHOLD_EN
        check("nb1_bin", {31'd0, d1_out_bin}, 0);
`endif
        @(negedge clk);
        check("nb1_drained", {31'd0, d1_out_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
